// File: rtl/spi_pkg.sv
// Shared frame layout, widths and FSM encoding for the SPI-to-memory bridge.
package spi_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    // Bit positions inside the 32-bit frame; the header is frame[31:16].
    localparam int RW_BIT  = 31;
    localparam int ADDR_LO = 16;

    typedef logic [5:0] cnt_t;

    localparam cnt_t FRAME_LEN = 6'd32;
    localparam cnt_t HDR_LEN   = 6'd16;

    localparam logic [DATA_W-1:0] RD_TIMEOUT_DEFAULT = 16'hDEAD;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RDREQ,
        DATA,
        WRREQ
    } state_t;

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Word-wide memory request/acknowledge bus driven by the SPI bridge.
interface spi_mem_bridge_if;
    import spi_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser with registered-history edge detection.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic [STAGES:0]   nxt;
    logic              prev;

    assign nxt = {sync, d};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= nxt[STAGES-1:0];
            prev <= level;
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns 32-bit frames into single-word memory
// reads and writes.
module spi_mem_bridge
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES     = 2,
    parameter logic [DATA_W-1:0] RD_TIMEOUT_DATA = RD_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_done,
    output logic              frame_err
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    // cs resets as "selected" so a frame in flight at reset never
    // looks like a fresh falling edge afterwards.
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d(spi_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .reset(reset), .d(spi_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

    state_t            state;
    cnt_t              cnt;
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] shin;
    logic              rw;
    logic              miso_q;
    logic              timed_out;
    logic              cs_gone;
    logic              bit_in;
    logic              shift_fall;
    logic              first_fall;

    assign shin       = {rx[DATA_W-2:0], mosi_lvl};
    assign bit_in     = sck_rise & ~cs_lvl & (cnt < FRAME_LEN);
    assign shift_fall = sck_fall & ~cs_lvl & (cnt >= HDR_LEN) & (cnt < FRAME_LEN);
    assign first_fall = shift_fall & (cnt == HDR_LEN);

    assign spi_miso = miso_q & ((state == RDREQ) | (state == DATA));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rx         <= '0;
            tx         <= '0;
            rw         <= 1'b0;
            miso_q     <= 1'b0;
            timed_out  <= 1'b0;
            cs_gone    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_in) begin
                rx  <= shin;
                cnt <= cnt + 6'd1;
            end
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= HDR;
                        cnt       <= '0;
                        rx        <= '0;
                        tx        <= '0;
                        miso_q    <= 1'b0;
                        timed_out <= 1'b0;
                        cs_gone   <= 1'b0;
                    end
                end
                HDR: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (bit_in && cnt == HDR_LEN - 6'd1) begin
                        rw       <= shin[RW_BIT-DATA_W];
                        mem_addr <= shin[ADDR_LO-DATA_W +: ADDR_W];
                        if (shin[RW_BIT-DATA_W]) begin
                            state <= DATA;
                        end else begin
                            state   <= RDREQ;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                RDREQ: begin
                    if (cs_rise) begin
                        cs_gone <= 1'b1;
                        if (cnt < FRAME_LEN && !timed_out) frame_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= (cs_gone || cs_rise) ? IDLE : DATA;
                        if (!timed_out) tx <= mem_rdata;
                    end
                    // Late data loses to the timeout word if both land together.
                    if (first_fall) begin
                        timed_out <= 1'b1;
                        frame_err <= 1'b1;
                        miso_q    <= RD_TIMEOUT_DATA[DATA_W-1];
                        tx        <= {RD_TIMEOUT_DATA[DATA_W-2:0], 1'b0};
                    end else if (shift_fall) begin
                        miso_q <= tx[DATA_W-1];
                        tx     <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (cnt < FRAME_LEN) begin
                            if (!timed_out) frame_err <= 1'b1;
                        end else if (!rw && !timed_out) begin
                            frame_done <= 1'b1;
                        end
                    end else if (rw && bit_in && cnt == FRAME_LEN - 6'd1) begin
                        state     <= WRREQ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= shin;
                    end
                    if (!rw && shift_fall) begin
                        miso_q <= tx[DATA_W-1];
                        tx     <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
                WRREQ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboard bench for spi_mem_bridge: SPI master model, memory responder
// and request/MISO queues.
module tb_spi_mem_bridge;
    import spi_pkg::*;

    localparam int HALF = 160;

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic frame_done;
    logic frame_err;

    spi_mem_bridge_if bus();

    int n_checks = 0;
    int n_errors = 0;
    int n_req = 0;
    int n_done = 0;
    int n_err = 0;
    int s_req = 0;
    int s_done = 0;
    int s_err = 0;
    int ack_delay = 2;
    logic [15:0] rd_val = 16'h0;

    req_t exp_q[$];
    logic [15:0] rd_q[$];
    req_t e_r;
    req_t cap_r;
    logic req_q = 1'b0;
    logic ack_q = 1'b0;

    always #5 clk = ~clk;

    spi_mem_bridge dut (
        .clk(clk),
        .reset(reset),
        .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .mem_req(bus.mem_req),
        .mem_we(bus.mem_we),
        .mem_addr(bus.mem_addr),
        .mem_wdata(bus.mem_wdata),
        .mem_ack(bus.mem_ack),
        .mem_rdata(bus.mem_rdata),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic counts(input string tag, input int req, input int done,
                          input int err);
        check({tag, "_nreq"}, 32'(n_req - s_req), 32'(req));
        check({tag, "_done"}, 32'(n_done - s_done), 32'(done));
        check({tag, "_err"}, 32'(n_err - s_err), 32'(err));
        s_req = n_req;
        s_done = n_done;
        s_err = n_err;
    endtask

    task automatic xfer(input logic [31:0] fr, input int nbits,
                        input bit end_cs, output logic [15:0] rx,
                        output logic hdr_miso);
        logic [31:0] sh;
        sh = fr;
        rx = '0;
        hdr_miso = 1'b0;
        spi_cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = sh[31];
            sh = sh << 1;
            #(HALF);
            spi_sck = 1'b1;
            if (i < 16) hdr_miso = hdr_miso | spi_miso;
            else if (i < 32) rx = {rx[14:0], spi_miso};
            #(HALF);
            spi_sck = 1'b0;
        end
        if (end_cs) begin
            #(HALF);
            spi_cs_n = 1'b1;
            #(2 * HALF);
        end
    endtask

    // Memory responder: acks ack_delay clocks after mem_req rises.
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req) begin
                for (int k = 1; k < ack_delay; k++) begin
                    @(posedge clk);
                    #2;
                end
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd_val;
                @(posedge clk);
                #2;
                bus.mem_ack = 1'b0;
                bus.mem_rdata = 16'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req && !req_q) begin
            n_req++;
            check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e_r = exp_q.pop_front();
                cap_r = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
                check("req_we", 32'(bus.mem_we), 32'(e_r.we));
                check("req_addr", 32'(bus.mem_addr), 32'(e_r.addr));
                if (e_r.we) check("req_wdata", 32'(bus.mem_wdata), 32'(e_r.wdata));
            end
        end
        if (bus.mem_req && bus.mem_ack) begin
            check("hold_we", 32'(bus.mem_we), 32'(cap_r.we));
            check("hold_addr", 32'(bus.mem_addr), 32'(cap_r.addr));
            check("hold_wdata", 32'(bus.mem_wdata), 32'(cap_r.wdata));
        end
        if (ack_q) check("req_drop", 32'(bus.mem_req), 32'd0);
        req_q = bus.mem_req;
        ack_q = bus.mem_req & bus.mem_ack;
        if (frame_done) n_done++;
        if (frame_err) n_err++;
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        logic hm;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        repeat (4) @(negedge clk);

        exp_q.push_back('{1'b1, 13'd100, 16'd2});
        ack_delay = 2;
        xfer(32'h8064_0002, 32, 1'b1, rx, hm);
        counts("wr", 1, 1, 0);

        exp_q.push_back('{1'b0, 13'd100, 16'd0});
        rd_q.push_back(16'h1234);
        ack_delay = 3;
        rd_val = 16'h1234;
        xfer(32'h0064_0000, 32, 1'b1, rx, hm);
        check("rd_miso", 32'(rx), 32'(rd_q.pop_front()));
        check("rd_hdr_miso", 32'(hm), 32'd0);
        counts("rd", 1, 1, 0);

        exp_q.push_back('{1'b0, 13'd100, 16'd0});
        rd_q.push_back(16'hDEAD);
        ack_delay = 200;
        rd_val = 16'hBEEF;
        xfer(32'h0064_0000, 32, 1'b1, rx, hm);
        check("to_miso", 32'(rx), 32'(rd_q.pop_front()));
        counts("to", 1, 0, 1);

        ack_delay = 2;
        xfer(32'h8064_0002, 20, 1'b1, rx, hm);
        counts("abort", 0, 0, 1);
        check("abort_idle", 32'(dut.state), 32'(IDLE));

        xfer(32'h8064_0002, 10, 1'b0, rx, hm);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(bus.mem_req), 32'd0);
        spi_cs_n = 1'b1;
        #(2 * HALF);
        exp_q.push_back('{1'b1, 13'd1, 16'h00FF});
        xfer(32'h8001_00FF, 32, 1'b1, rx, hm);
        counts("midrst", 1, 1, 0);

        exp_q.push_back('{1'b0, 13'h1FFF, 16'd0});
        rd_q.push_back(16'hA5C3);
        ack_delay = 1;
        rd_val = 16'hA5C3;
        xfer(32'h7FFF_0000, 32, 1'b1, rx, hm);
        check("rdmax_miso", 32'(rx), 32'(rd_q.pop_front()));
        counts("rdmax", 1, 1, 0);

        exp_q.push_back('{1'b1, 13'd0, 16'hFFFF});
        ack_delay = 2;
        xfer(32'hE000_FFFF, 34, 1'b1, rx, hm);
        counts("wrx", 1, 1, 0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
